// File: rtl/pooling_pkg.sv
// Shared definitions for the pooling window unit: reduction mode encoding,
// lane slicing and the shift used to finalise averaging windows.
package pooling_pkg;

    // Reduction applied across the beats of one window
    typedef enum logic [1:0] {
        POOL_MAX = 2'd0,
        POOL_MIN = 2'd1,
        POOL_AVG = 2'd2,
        POOL_SUM = 2'd3
    } pool_mode_e;

    // Widest packed lane bus and widest single lane that lane_sel can slice
    localparam int POOL_BUS_MAX  = 2048;
    localparam int POOL_LANE_MAX = 64;

    // Returns lane j (w bits wide) of a packed bus in its low bits; the caller
    // zero-extends its bus to POOL_BUS_MAX and keeps the low w bits of the result
    function automatic logic [POOL_LANE_MAX-1:0] lane_sel(
        input logic [POOL_BUS_MAX-1:0] bus,
        input int                      j,
        input int                      w
    );
        return POOL_LANE_MAX'(bus >> (j * w));
    endfunction

    // ceil(log2(win_m1 + 1)): right shift that turns a window sum into an
    // average; exact for power-of-two windows, truncating otherwise
    function automatic int clog2_win(input int unsigned win_m1);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((32'd1 << k) < (win_m1 + 32'd1)) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pooling_lane_reduce.sv
// One pooling lane: running accumulator, compare/add against the incoming
// beat, and the finalise step that turns the folded value into a W-bit result.
module pooling_lane_reduce
    import pooling_pkg::*;
#(
    parameter int W          = 8,
    parameter int MAXWIN_LOG = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  pool_mode_e            mode,
    input  logic [MAXWIN_LOG-1:0] win_m1,
    input  logic                  lane_en,
    input  logic                  first_beat,
    input  logic                  accept,
    input  logic                  final_beat,
    input  logic                  flush,
    input  logic [W-1:0]          in_value,
    output logic [W-1:0]          result
);

    // Wide enough that 2^MAXWIN_LOG beats of 2^W-1 never wrap
    localparam int AW = W + MAXWIN_LOG;

    logic [AW-1:0] acc;
    logic [AW-1:0] in_ext;
    logic [AW-1:0] comb_val;
    int            avg_shift;

    assign in_ext = AW'(in_value);

    // Running value with the current beat folded in
    always_comb begin
        // NOTE: comb_val gets a default before any branch, so every path
        // assigns it and no latch is inferred.
        comb_val = in_ext;
        if (!first_beat) begin
            case (mode)
                POOL_MAX: comb_val = (in_ext > acc) ? in_ext : acc;
                POOL_MIN: comb_val = (in_ext < acc) ? in_ext : acc;
                POOL_AVG,
                POOL_SUM: comb_val = acc + in_ext;
            endcase
        end
    end

    // Accumulator: loads on accepted beats, empties on window end or flush
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: the accumulator is reset even though the first beat of a
        // window overwrites it, so an idle lane is a known zero, never X.
        if (!RST_N) begin
            acc <= '0;
        end else if (flush || final_beat) begin
            acc <= '0;
        end else if (accept) begin
            acc <= comb_val;
        end
    end

    // Finalise: pick the W-bit result for this mode; disabled lanes read 0
    always_comb begin
        result    = '0;
        avg_shift = clog2_win(32'(win_m1));
        if (lane_en) begin
            case (mode)
                POOL_MAX,
                POOL_MIN: result = comb_val[W-1:0];
                POOL_AVG: result = W'(comb_val >> avg_shift);
                POOL_SUM: result = (comb_val[AW-1:W] != '0) ? '1 : comb_val[W-1:0];
            endcase
        end
    end

endmodule

// File: rtl/pooling_window_unit.sv
// Streaming pooling engine: D lanes each reduce a configurable window of
// accepted beats into one registered result, with valid/ready on both sides,
// per-window config latching, per-lane enables and a synchronous flush.
module pooling_window_unit
    import pooling_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  int W          = 8,
    parameter  int MAXWIN_LOG = 4,
    localparam int D          = 1 << DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [1:0]            cfg_mode,
    input  logic [MAXWIN_LOG-1:0] cfg_win_m1,
    input  logic [D-1:0]          cfg_lane_en,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W*D-1:0]        in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W*D-1:0]        out_data,
    output logic                  busy
);

    logic [MAXWIN_LOG-1:0] count;
    pool_mode_e            mode_q;
    logic [MAXWIN_LOG-1:0] win_m1_q;
    logic [D-1:0]          lane_en_q;

    pool_mode_e            eff_mode;
    logic [MAXWIN_LOG-1:0] eff_win_m1;
    logic [D-1:0]          eff_lane_en;
    logic                  first_beat;
    logic                  accept;
    logic                  final_beat;
    logic [W*D-1:0]        lane_result;

    // At window start the live config applies; mid-window the latched copy does
    assign first_beat  = (count == '0);
    assign eff_mode    = first_beat ? pool_mode_e'(cfg_mode) : mode_q;
    assign eff_win_m1  = first_beat ? cfg_win_m1 : win_m1_q;
    assign eff_lane_en = first_beat ? cfg_lane_en : lane_en_q;

    // Only a final beat can be stalled, and only by an undrained result
    assign in_ready   = (count != eff_win_m1) || !out_valid || out_ready;
    assign accept     = in_valid && in_ready && !flush;
    assign final_beat = accept && (count == eff_win_m1);
    assign busy       = !first_beat;

    // Beat counter: wraps on the final beat, cleared by flush
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples pre-edge values regardless of evaluation order.
        if (!RST_N) begin
            count <= '0;
        end else if (flush || final_beat) begin
            count <= '0;
        end else if (accept) begin
            count <= count + 1'b1;
        end
    end

    // Config latch: captured on the first accepted beat of each window
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q    <= POOL_MAX;
            win_m1_q  <= '0;
            lane_en_q <= '0;
        end else if (accept && first_beat) begin
            mode_q    <= eff_mode;
            win_m1_q  <= eff_win_m1;
            lane_en_q <= eff_lane_en;
        end
    end

    // Single-entry output register; a new result may replace a draining one
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (final_beat) begin
            out_valid <= 1'b1;
            out_data  <= lane_result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar j = 0; j < D; j++) begin : g_lane
        pooling_lane_reduce #(
            .W          (W),
            .MAXWIN_LOG (MAXWIN_LOG)
        ) u_lane (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .mode       (eff_mode),
            .win_m1     (eff_win_m1),
            .lane_en    (eff_lane_en[j]),
            .first_beat (first_beat),
            .accept     (accept),
            .final_beat (final_beat),
            .flush      (flush),
            .in_value   (W'(lane_sel(POOL_BUS_MAX'(in_data), j, W))),
            .result     (lane_result[W*(j+1)-1 -: W])
        );
    end

endmodule
